// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: one load/store per pipeline slot,
// issued as an address phase then a data phase on an SRAM-like split bus.
module mem_access_ctrl #(
    parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_flag,
    input  logic        mem_write_flag,
    input  logic        mem_sign_ext_flag,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic        flush,
    input  logic        stall_in,
    output logic        stall_request,
    output logic [31:0] load_data,
    output logic        addr_error_load,
    output logic        addr_error_store,
    output logic        bus_en,
    output logic [3:0]  bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ADDR,
        WAIT_DATA,
        HOLD
    } state_t;

    state_t      state, state_d;
    logic        cancel, cancel_d;
    logic [31:0] load_q, load_d;
    logic        capture;

    logic [31:0] req_addr;
    logic [3:0]  req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_sel;
    logic        req_sign;

    logic        is_half, is_word, misaligned, valid_acc;
    logic [31:0] new_addr, new_wdata, rd_ext;
    logic [3:0]  new_wen;

    function automatic logic [31:0] extract(
        input logic [31:0] rd,
        input logic [3:0]  sel,
        input logic [1:0]  lo,
        input logic        sign
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lo, 3'b000} +: 8];
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (sel)
            4'b0001: extract = {{24{sign & b[7]}}, b};
            4'b0011: extract = {{16{sign & h[15]}}, h};
            default: extract = rd;
        endcase
    endfunction

    always_comb begin
        is_half          = (mem_sel == 4'b0011);
        is_word          = (mem_sel == 4'b1111);
        misaligned       = (is_half & mem_addr[0]) | (is_word & (|mem_addr[1:0]));
        addr_error_load  = mem_read_flag & misaligned;
        addr_error_store = mem_write_flag & misaligned;
        valid_acc        = (mem_read_flag | mem_write_flag) & ~misaligned & ~flush;
    end

    always_comb begin
        new_addr = mem_addr & ADDR_MASK;
        new_wen  = mem_write_flag ? (mem_sel << mem_addr[1:0]) : 4'b0000;
        case (mem_sel)
            4'b0001: new_wdata = {4{mem_write_data[7:0]}};
            4'b0011: new_wdata = {2{mem_write_data[15:0]}};
            default: new_wdata = mem_write_data;
        endcase
        rd_ext = extract(bus_rdata, req_sel, req_addr[1:0], req_sign);
    end

    always_comb begin
        state_d       = state;
        cancel_d      = cancel;
        load_d        = load_q;
        capture       = 1'b0;
        bus_en        = 1'b0;
        bus_wen       = 4'b0000;
        bus_addr      = 32'h0;
        bus_wdata     = 32'h0;
        stall_request = 1'b0;
        load_data     = load_q;
        unique case (state)
            IDLE: begin
                if (valid_acc) begin
                    bus_en        = 1'b1;
                    bus_wen       = new_wen;
                    bus_addr      = new_addr;
                    bus_wdata     = new_wdata;
                    stall_request = 1'b1;
                    capture       = 1'b1;
                    state_d       = bus_addr_ok ? WAIT_DATA : WAIT_ADDR;
                end
            end
            WAIT_ADDR: begin
                bus_en        = 1'b1;
                bus_wen       = req_wen;
                bus_addr      = req_addr;
                bus_wdata     = req_wdata;
                stall_request = cancel ? valid_acc : 1'b1;
                if (flush)
                    cancel_d = 1'b1;
                if (bus_addr_ok)
                    state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                stall_request = cancel ? valid_acc : 1'b1;
                if (flush)
                    cancel_d = 1'b1;
                if (bus_data_ok) begin
                    cancel_d = 1'b0;
                    // A flushed access still drains, but its data is dropped
                    if (cancel | flush) begin
                        stall_request = valid_acc;
                        state_d       = IDLE;
                    end else begin
                        stall_request = 1'b0;
                        load_data     = rd_ext;
                        load_d        = rd_ext;
                        state_d       = stall_in ? HOLD : IDLE;
                    end
                end
            end
            HOLD: begin
                if (!stall_in || flush)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cancel    <= 1'b0;
            load_q    <= 32'h0;
            req_addr  <= 32'h0;
            req_wen   <= 4'b0000;
            req_wdata <= 32'h0;
            req_sel   <= 4'b0000;
            req_sign  <= 1'b0;
        end else begin
            state  <= state_d;
            cancel <= cancel_d;
            load_q <= load_d;
            if (capture) begin
                req_addr  <= new_addr;
                req_wen   <= new_wen;
                req_wdata <= new_wdata;
                req_sel   <= mem_sel;
                req_sign  <= mem_sign_ext_flag;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr, mem_write_data;
    logic        flush, stall_in;
    logic        stall_request;
    logic [31:0] load_data;
    logic        addr_error_load, addr_error_store;
    logic        bus_en;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read_flag    (mem_read_flag),
        .mem_write_flag   (mem_write_flag),
        .mem_sign_ext_flag(mem_sign_ext_flag),
        .mem_sel          (mem_sel),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .flush            (flush),
        .stall_in         (stall_in),
        .stall_request    (stall_request),
        .load_data        (load_data),
        .addr_error_load  (addr_error_load),
        .addr_error_store (addr_error_store),
        .bus_en           (bus_en),
        .bus_wen          (bus_wen),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_addr_ok      (bus_addr_ok),
        .bus_data_ok      (bus_data_ok),
        .bus_rdata        (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        mem_read_flag     = 1'b0;
        mem_write_flag    = 1'b0;
        mem_sign_ext_flag = 1'b0;
        mem_sel           = 4'b0000;
        mem_addr          = 32'h0;
        mem_write_data    = 32'h0;
        flush             = 1'b0;
        stall_in          = 1'b0;
        bus_addr_ok       = 1'b0;
        bus_data_ok       = 1'b0;
        bus_rdata         = 32'h0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Single-cycle bus load: issue with addr_ok, data_ok next cycle
    task automatic do_load(input string tag, input logic [31:0] addr,
                           input logic [3:0] sel, input logic sign,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [31:0] exp);
        step();
        idle_in();
        mem_read_flag     = 1'b1;
        mem_sel           = sel;
        mem_sign_ext_flag = sign;
        mem_addr          = addr;
        bus_addr_ok       = 1'b1;
        #1;
        check({tag, "_bus_en"}, 32'(bus_en), 32'd1);
        check({tag, "_bus_addr"}, bus_addr, exp_addr);
        check({tag, "_bus_wen"}, 32'(bus_wen), 32'h0);
        check({tag, "_stall_issue"}, 32'(stall_request), 32'd1);
        step();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = rdata;
        #1;
        check({tag, "_load_data"}, load_data, exp);
        check({tag, "_stall_done"}, 32'(stall_request), 32'd0);
        check({tag, "_bus_en_done"}, 32'(bus_en), 32'd0);
        step();
        idle_in();
        #1;
        check({tag, "_bus_en_after"}, 32'(bus_en), 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr,
                            input logic [3:0] sel, input logic [31:0] wd,
                            input logic [3:0] exp_wen, input logic [31:0] exp_wd);
        step();
        idle_in();
        mem_write_flag = 1'b1;
        mem_sel        = sel;
        mem_addr       = addr;
        mem_write_data = wd;
        bus_addr_ok    = 1'b1;
        #1;
        check({tag, "_bus_en"}, 32'(bus_en), 32'd1);
        check({tag, "_bus_wen"}, 32'(bus_wen), 32'(exp_wen));
        check({tag, "_bus_wdata"}, bus_wdata, exp_wd);
        check({tag, "_ades"}, 32'(addr_error_store), 32'd0);
        check({tag, "_stall_issue"}, 32'(stall_request), 32'd1);
        step();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        #1;
        check({tag, "_stall_done"}, 32'(stall_request), 32'd0);
        step();
        idle_in();
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        step();
        step();
        #1;
        check("rst_bus_en", 32'(bus_en), 32'd0);
        check("rst_stall", 32'(stall_request), 32'd0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_bus_wen", 32'(bus_wen), 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        step();
        rst = 1'b0;

        // Word, byte and half loads
        do_load("lw", 32'h8000_0010, 4'b1111, 1'b0, 32'hDEAD_BEEF,
                32'h0000_0010, 32'hDEAD_BEEF);
        do_load("lb", 32'h8000_0003, 4'b0001, 1'b1, 32'h8011_2233,
                32'h0000_0003, 32'hFFFF_FF80);
        do_load("lbu", 32'h8000_0003, 4'b0001, 1'b0, 32'h8011_2233,
                32'h0000_0003, 32'h0000_0080);
        do_load("lh", 32'h8000_0002, 4'b0011, 1'b1, 32'h8011_2233,
                32'h0000_0002, 32'hFFFF_8011);
        do_load("lhu", 32'h8000_0000, 4'b0011, 1'b0, 32'h8011_2233,
                32'h0000_0000, 32'h0000_2233);

        // Stores and lane replication
        do_store("sh", 32'h8000_0002, 4'b0011, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
        do_store("sb", 32'h8000_0001, 4'b0001, 32'h0000_00EE, 4'b0010, 32'hEEEE_EEEE);

        // Misaligned word store: exception, no bus, no stall
        step();
        idle_in();
        mem_write_flag = 1'b1;
        mem_sel        = 4'b1111;
        mem_addr       = 32'h8000_0002;
        mem_write_data = 32'h1234_5678;
        bus_addr_ok    = 1'b1;
        #1;
        check("sw_mis_ades", 32'(addr_error_store), 32'd1);
        check("sw_mis_adel", 32'(addr_error_load), 32'd0);
        check("sw_mis_bus_en", 32'(bus_en), 32'd0);
        check("sw_mis_stall", 32'(stall_request), 32'd0);
        step();
        #1;
        check("sw_mis_bus_en2", 32'(bus_en), 32'd0);
        step();
        idle_in();
        mem_read_flag = 1'b1;
        mem_sel       = 4'b0011;
        mem_addr      = 32'h8000_0001;
        #1;
        check("lh_mis_adel", 32'(addr_error_load), 32'd1);
        check("lh_mis_bus_en", 32'(bus_en), 32'd0);
        check("lh_mis_stall", 32'(stall_request), 32'd0);

        // Slow bus: addr_ok after 3 cycles, data_ok 2 later, stall_in at data_ok
        stall_cnt = 0;
        step();
        idle_in();
        mem_read_flag = 1'b1;
        mem_sel       = 4'b1111;
        mem_addr      = 32'hBFC0_0004;
        #1;
        check("slow_bus_en0", 32'(bus_en), 32'd1);
        check("slow_bus_addr0", bus_addr, 32'h1FC0_0004);
        stall_cnt += int'(stall_request);
        for (int i = 1; i <= 2; i++) begin
            step();
            mem_addr = 32'h8000_0100;
            #1;
            check("slow_bus_en_wait", 32'(bus_en), 32'd1);
            check("slow_bus_addr_wait", bus_addr, 32'h1FC0_0004);
            stall_cnt += int'(stall_request);
        end
        step();
        bus_addr_ok = 1'b1;
        #1;
        check("slow_bus_en_aok", 32'(bus_en), 32'd1);
        check("slow_bus_addr_aok", bus_addr, 32'h1FC0_0004);
        stall_cnt += int'(stall_request);
        step();
        bus_addr_ok = 1'b0;
        #1;
        check("slow_bus_en_wd", 32'(bus_en), 32'd0);
        stall_cnt += int'(stall_request);
        step();
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h1234_5678;
        stall_in    = 1'b1;
        #1;
        check("slow_load_data", load_data, 32'h1234_5678);
        check("slow_stall_done", 32'(stall_request), 32'd0);
        stall_cnt += int'(stall_request);
        check("slow_stall_cycles", 32'(stall_cnt), 32'd5);
        for (int i = 0; i < 2; i++) begin
            step();
            bus_data_ok = 1'b0;
            bus_rdata   = 32'h0;
            #1;
            check("hold_bus_en", 32'(bus_en), 32'd0);
            check("hold_load_data", load_data, 32'h1234_5678);
            check("hold_stall", 32'(stall_request), 32'd0);
        end
        step();
        stall_in = 1'b0;
        #1;
        check("hold_exit_bus_en", 32'(bus_en), 32'd0);
        check("hold_exit_load_data", load_data, 32'h1234_5678);
        step();
        mem_addr    = 32'h8000_0200;
        bus_addr_ok = 1'b1;
        #1;
        check("post_hold_bus_en", 32'(bus_en), 32'd1);
        check("post_hold_bus_addr", bus_addr, 32'h0000_0200);
        step();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h55AA_55AA;
        #1;
        check("post_hold_load", load_data, 32'h55AA_55AA);
        step();
        idle_in();

        // Flush in WAIT_DATA with a new load right behind it
        step();
        idle_in();
        mem_read_flag = 1'b1;
        mem_sel       = 4'b1111;
        mem_addr      = 32'h8000_0020;
        bus_addr_ok   = 1'b1;
        #1;
        check("fl_issue_bus_en", 32'(bus_en), 32'd1);
        step();
        bus_addr_ok = 1'b0;
        flush       = 1'b1;
        #1;
        check("fl_flush_stall", 32'(stall_request), 32'd1);
        check("fl_flush_bus_en", 32'(bus_en), 32'd0);
        step();
        flush    = 1'b0;
        mem_addr = 32'h8000_0040;
        #1;
        check("fl_new_stall", 32'(stall_request), 32'd1);
        check("fl_new_bus_en", 32'(bus_en), 32'd0);
        step();
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hBAD0_BAD0;
        #1;
        check("fl_dok_stall", 32'(stall_request), 32'd1);
        check("fl_dok_bus_en", 32'(bus_en), 32'd0);
        check("fl_dok_discard", load_data, 32'h55AA_55AA);
        step();
        bus_data_ok = 1'b0;
        bus_addr_ok = 1'b1;
        #1;
        check("fl_reissue_bus_en", 32'(bus_en), 32'd1);
        check("fl_reissue_addr", bus_addr, 32'h0000_0040);
        check("fl_reissue_stall", 32'(stall_request), 32'd1);
        step();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h0000_CAFE;
        #1;
        check("fl_new_load", load_data, 32'h0000_CAFE);
        check("fl_new_stall_done", 32'(stall_request), 32'd0);
        step();
        idle_in();

        // Reset while waiting for the address phase
        step();
        idle_in();
        mem_read_flag = 1'b1;
        mem_sel       = 4'b1111;
        mem_addr      = 32'h8000_0080;
        step();
        rst = 1'b1;
        #1;
        check("rst_wa_bus_en_before", 32'(bus_en), 32'd1);
        step();
        rst = 1'b0;
        idle_in();
        #1;
        check("rst_wa_bus_en", 32'(bus_en), 32'd0);
        check("rst_wa_stall", 32'(stall_request), 32'd0);
        check("rst_wa_load_data", load_data, 32'h0);
        do_load("rst_lw", 32'h8000_0084, 4'b1111, 1'b0, 32'h0000_0001,
                32'h0000_0084, 32'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
